// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Digit-serial two's-complement subtractor for the FIR datapath.
// Computes diff = in_1 - in_2 - borrow_in, processing `digit` bits per clock
// from LSB to MSB. The borrow between slices is kept in a flip-flop, so one
// operation takes N = width/digit RUN cycles.
//
// Parameters
//   width       operand / result width in bits
//   digit       bits processed per RUN cycle (width % digit == 0)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    operands and borrow_in are valid
//   in_ready    block can accept an operation (IDLE)
//   in_1        minuend
//   in_2        subtrahend
//   borrow_in   borrow into the LSB
//   out_valid   result valid (DONE)
//   out_ready   consumer accepts the result
//   diff        in_1 - in_2 - borrow_in, modulo 2^width
//   borrow_out  unsigned borrow: 1 iff in_1 < in_2 + borrow_in
//   overflow    signed overflow of the subtraction
// ---------------------------------------------------------------------------

// One digit slice: a - b - borrow evaluated one bit wider than the slice.
// The extra MSB goes to 1 exactly when the slice result went negative,
// which is the borrow into the next slice.
module serial_subtractor_slice #(
    parameter int digit = 4
) (
    input  logic [digit-1:0] i_a,
    input  logic [digit-1:0] i_b,
    input  logic             i_borrow,
    output logic [digit-1:0] o_d,
    output logic             o_borrow
);

    logic [digit:0] w_d;

    assign w_d      = {1'b0, i_a} - {1'b0, i_b} - {{digit{1'b0}}, i_borrow};
    assign o_d      = w_d[digit-1:0];
    assign o_borrow = w_d[digit];

endmodule

module serial_subtractor #(
    parameter int width = 16,
    parameter int digit = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_1,
    input  logic [width-1:0] in_2,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int N   = width / digit;
    localparam int CW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = width - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [width-1:0] r_a;
    logic [width-1:0] r_b;
    logic [width-1:0] r_res;        // slices completed so far
    logic [width-1:0] r_diff;
    logic             r_borrow;     // borrow between slices
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [digit-1:0] w_a_sl;
    logic [digit-1:0] w_b_sl;
    logic [digit-1:0] w_d_sl;
    logic             w_borrow_nx;
    logic [width-1:0] w_res_nx;     // r_res with the current slice merged in
    logic             w_last;

    // Slice select and result merge. With a single slice there is nothing
    // to select, and indexing a one-entry array would need a zero-bit index.
    generate
        if (N == 1) begin : g_single
            assign w_a_sl   = r_a;
            assign w_b_sl   = r_b;
            assign w_res_nx = w_d_sl;
        end else begin : g_multi
            logic [N-1:0][digit-1:0] w_a_arr;
            logic [N-1:0][digit-1:0] w_b_arr;
            logic [N-1:0][digit-1:0] w_res_arr;

            assign w_a_arr = r_a;
            assign w_b_arr = r_b;
            assign w_a_sl  = w_a_arr[r_cnt];
            assign w_b_sl  = w_b_arr[r_cnt];

            always_comb begin
                w_res_arr        = r_res;
                w_res_arr[r_cnt] = w_d_sl;
            end

            assign w_res_nx = w_res_arr;
        end
    endgenerate

    serial_subtractor_slice #(.digit(digit)) u_slice (
        .i_a      (w_a_sl),
        .i_b      (w_b_sl),
        .i_borrow (r_borrow),
        .o_d      (w_d_sl),
        .o_borrow (w_borrow_nx)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    // Control and datapath in one block. Handshake outputs are registered
    // alongside the state so they never depend combinationally on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is 1 throughout IDLE, so in_valid alone
                    // completes the input handshake here.
                    if (in_valid) begin
                        r_a        <= in_1;
                        r_b        <= in_2;
                        r_borrow   <= borrow_in;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_res    <= w_res_nx;
                    r_borrow <= w_borrow_nx;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Published outputs only change here, so they keep
                        // the last result between operations.
                        r_diff       <= w_res_nx;
                        r_borrow_out <= w_borrow_nx;
                        r_overflow   <= (r_a[MSB] != r_b[MSB]) &&
                                        (w_res_nx[MSB] != r_a[MSB]);
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    // No accept on this edge: in_ready rises only once the
                    // block is back in IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Three instances (digit = 1, 4, 16; width = 16) share one clock and reset.
// A behavioural model, computed with integer arithmetic, predicts in_ready,
// out_valid and the published result of every instance on every cycle.
// Directed operations with literal expectations run on the digit=4 instance,
// then a randomized sweep with output stalls runs on each instance.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W  = 16;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid   [NI];
    logic          in_ready   [NI];
    logic [W-1:0]  in_1       [NI];
    logic [W-1:0]  in_2       [NI];
    logic          borrow_in  [NI];
    logic          out_valid  [NI];
    logic          out_ready  [NI];
    logic [W-1:0]  diff       [NI];
    logic          borrow_out [NI];
    logic          overflow   [NI];

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
            serial_subtractor #(.width(W), .digit(DG)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid[g]),
                .in_ready   (in_ready[g]),
                .in_1       (in_1[g]),
                .in_2       (in_2[g]),
                .borrow_in  (borrow_in[g]),
                .out_valid  (out_valid[g]),
                .out_ready  (out_ready[g]),
                .diff       (diff[g]),
                .borrow_out (borrow_out[g]),
                .overflow   (overflow[g])
            );
        end
    endgenerate

    // RUN cycles per operation for each instance
    function automatic int n_of(input int i);
        return (i == 0) ? 16 : ((i == 1) ? 4 : 1);
    endfunction

    // Reference result {overflow, borrow_out, diff} from plain integers.
    function automatic bit [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
        int ua, ub, bi, r, sd;
        bit bo, ov;
        ua = int'(a);
        ub = int'(b);
        bi = bin ? 1 : 0;
        r  = ua - ub - bi;
        bo = (ua < ub + bi);
        sd = int'($signed(a)) - int'($signed(b)) - bi;
        ov = (sd > 32767) || (sd < -32768);
        return {ov, bo, 16'(r)};
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h expected=%h", name, i, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit        m_busy [NI];
    int        m_cnt  [NI];   // RUN edges still to come; 0 while busy = DONE
    bit [17:0] m_pend [NI];
    bit [17:0] m_vis  [NI];   // what diff/borrow_out/overflow show now

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                check("in_ready",   i, in_ready[i],   !m_busy[i]);
                check("out_valid",  i, out_valid[i],  m_busy[i] && (m_cnt[i] == 0));
                check("diff",       i, diff[i],       m_vis[i][15:0]);
                check("borrow_out", i, borrow_out[i], m_vis[i][16]);
                check("overflow",   i, overflow[i],   m_vis[i][17]);
            end
        end
        // Inputs are stable until the next rising edge: advance the model.
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_cnt[i]  = 0;
                m_vis[i]  = '0;
            end else if (!m_busy[i]) begin
                if (in_valid[i]) begin
                    m_busy[i] = 1'b1;
                    m_cnt[i]  = n_of(i);
                    m_pend[i] = ref_sub(in_1[i], in_2[i], borrow_in[i]);
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) m_vis[i] = m_pend[i];
            end else if (out_ready[i]) begin
                m_busy[i] = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input int stall,
                          output logic [15:0] d, output logic bo, output logic ov,
                          output int lat);
        int t;
        t = 0;
        while (in_ready[i] !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_wait", i, (t < 100), 1);
        in_1[i]      = a;
        in_2[i]      = b;
        borrow_in[i] = bin;
        in_valid[i]  = 1'b1;
        out_ready[i] = (stall == 0);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        lat = 0;
        while (out_valid[i] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = diff[i];
        bo = borrow_out[i];
        ov = overflow[i];
        for (int s = 0; s < stall; s++) begin
            // new operands offered while DONE must be ignored
            in_valid[i]  = 1'($urandom_range(0, 1));
            in_1[i]      = 16'($urandom);
            in_2[i]      = 16'($urandom);
            borrow_in[i] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("bp_in_ready", i, in_ready[i], 0);
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic        bo, ov;
        int          lat;
        logic [15:0] ra, rb;
        logic        rbin;
        int          st;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_1[i]      = '0;
            in_2[i]      = '0;
            borrow_in[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        armed = 1'b1;
        rst   = 1'b0;

        // pin the model
        check("model_pin_a", 0, 32'(ref_sub(16'h7FFF, 16'hFFFF, 1'b0)), 32'h3_8000);
        check("model_pin_b", 0, 32'(ref_sub(16'h0005, 16'h0005, 1'b1)), 32'h1_FFFF);

        // reset state
        check("rst_in_ready",  1, in_ready[1],  1);
        check("rst_out_valid", 1, out_valid[1], 0);
        check("rst_diff",      1, diff[1],      0);

        // directed ops on digit=4
        run_op(1, 16'h1234, 16'h0034, 1'b0, 0, d, bo, ov, lat);
        check("op1_diff", 1, d, 16'h1200);
        check("op1_bo",   1, bo, 0);
        check("op1_ov",   1, ov, 0);
        check("op1_lat",  1, lat, 4);

        run_op(1, 16'h0000, 16'h0001, 1'b0, 0, d, bo, ov, lat);
        check("op2_diff", 1, d, 16'hFFFF);
        check("op2_bo",   1, bo, 1);
        check("op2_ov",   1, ov, 0);

        run_op(1, 16'h0005, 16'h0005, 1'b1, 0, d, bo, ov, lat);
        check("op3_diff", 1, d, 16'hFFFF);
        check("op3_bo",   1, bo, 1);
        check("op3_ov",   1, ov, 0);

        run_op(1, 16'h8000, 16'h0001, 1'b0, 0, d, bo, ov, lat);
        check("op4_diff", 1, d, 16'h7FFF);
        check("op4_bo",   1, bo, 0);
        check("op4_ov",   1, ov, 1);

        // backpressure: 5 stalled cycles with new operands offered
        run_op(1, 16'h7FFF, 16'hFFFF, 1'b0, 5, d, bo, ov, lat);
        check("op5_diff", 1, d, 16'h8000);
        check("op5_bo",   1, bo, 1);
        check("op5_ov",   1, ov, 1);
        check("op5_after_in_ready", 1, in_ready[1], 1);

        run_op(1, 16'h0100, 16'h0001, 1'b0, 0, d, bo, ov, lat);
        check("op6_diff", 1, d, 16'h00FF);
        check("op6_bo",   1, bo, 0);

        // reset during the second RUN cycle
        in_1[1]      = 16'h4321;
        in_2[1]      = 16'h1111;
        borrow_in[1] = 1'b0;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready[1] = 1'b0;
        check("mrst_in_ready",  1, in_ready[1],   1);
        check("mrst_out_valid", 1, out_valid[1],  0);
        check("mrst_diff",      1, diff[1],       0);
        check("mrst_bo",        1, borrow_out[1], 0);
        check("mrst_ov",        1, overflow[1],   0);

        run_op(1, 16'h00FF, 16'h0100, 1'b0, 0, d, bo, ov, lat);
        check("op7_diff", 1, d, 16'hFFFF);
        check("op7_bo",   1, bo, 1);
        check("op7_ov",   1, ov, 0);

        // random sweep on every digit configuration
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 1000; k++) begin
                ra   = 16'($urandom);
                rb   = 16'($urandom);
                rbin = 1'($urandom_range(0, 1));
                if (k % 50 == 0) rb = ra;   // zero / all-ones corner
                st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                run_op(i, ra, rb, rbin, st, d, bo, ov, lat);
                check("rand_lat", i, lat, n_of(i));
            end
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
